// File: rtl/ack_sequence_controller.sv
// ---------------------------------------------------------------------------
// ack_sequence_controller
//
// Upstream sequencer for the interrupt acknowledge data path. It follows the
// INTA pulse train and poll reads and reports the phase on control_state
// (0 READY, 1 ACK1, 2 ACK2, 3 ACK3, 4 POLL). On the first INTA it latches the
// winning request and decides whether this device or a cascaded slave drives
// the vector bytes. It also issues the one-cycle pulses that the in-service
// logic uses to open and close an acknowledge sequence.
//
// Ports
//   clock, reset_n                 system clock / async active-low reset
//   interrupt_acknowledge_n        INTA pin, active low, asynchronous
//   read                           CPU read strobe, active high, asynchronous
//   poll_command                   1-cycle pulse: poll request written
//   write_initial_command_word_1   1-cycle pulse: ICW1 write, aborts a sequence
//   u8086_or_mcs80_config          0 = MCS-80 (3 INTA pulses), 1 = 8086 (2)
//   single_or_cascade_config       1 = single device, 0 = cascaded
//   cascade_slave                  1 = this device is a slave
//   cascade_device_config[7:0]     master: slave-present mask, slave: [2:0] ID
//   highest_level_in_request[7:0]  one-hot winning request (0 = none)
//   cascade_in[2:0]                CAS lines as seen by a slave
//   control_state[2:0]             current acknowledge phase
//   interrupt_when_ack1[7:0]       request captured on ACK1 entry
//   cascade_output_ack_2_3         this device drives the ACK2/ACK3 bytes
//   cascade_out[2:0], cascade_io   CAS ID driven by a master, and its enable
//   latch_in_service               pulse on ACK1 entry
//   end_of_acknowledge_sequence    pulse when the final INTA pulse ends
//   end_of_poll_command            pulse when the poll read completes
// ---------------------------------------------------------------------------
module ack_sequence_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       interrupt_acknowledge_n,
    input  logic       read,
    input  logic       poll_command,
    input  logic       write_initial_command_word_1,
    input  logic       u8086_or_mcs80_config,
    input  logic       single_or_cascade_config,
    input  logic       cascade_slave,
    input  logic [7:0] cascade_device_config,
    input  logic [7:0] highest_level_in_request,
    input  logic [2:0] cascade_in,
    output logic [2:0] control_state,
    output logic [7:0] interrupt_when_ack1,
    output logic       cascade_output_ack_2_3,
    output logic [2:0] cascade_out,
    output logic       cascade_io,
    output logic       latch_in_service,
    output logic       end_of_acknowledge_sequence,
    output logic       end_of_poll_command
);

    typedef enum logic [2:0] {
        ST_READY = 3'd0,
        ST_ACK1  = 3'd1,
        ST_ACK2  = 3'd2,
        ST_ACK3  = 3'd3,
        ST_POLL  = 3'd4
    } state_e;

    // -----------------------------------------------------------------------
    // Input synchronisers. The INTA chain resets to 1 (pin idle high) so that
    // leaving reset never looks like a falling edge.
    // -----------------------------------------------------------------------
    logic inta_sync;
    logic read_sync;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign inta_sync = interrupt_acknowledge_n;
            assign read_sync = read;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] inta_sync_q, inta_sync_d;
            logic [SYNC_STAGES-1:0] read_sync_q, read_sync_d;

            always_comb begin
                inta_sync_d    = inta_sync_q << 1;
                inta_sync_d[0] = interrupt_acknowledge_n;
                read_sync_d    = read_sync_q << 1;
                read_sync_d[0] = read;
            end

            // NOTE: sequential state is updated with non-blocking assignments so
            // every flop samples the pre-edge value of its neighbours.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    inta_sync_q <= '1;
                    read_sync_q <= '0;
                end else begin
                    inta_sync_q <= inta_sync_d;
                    read_sync_q <= read_sync_d;
                end
            end

            assign inta_sync = inta_sync_q[SYNC_STAGES-1];
            assign read_sync = read_sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State and registered outputs
    // -----------------------------------------------------------------------
    state_e     state_q, state_d;
    logic       inta_hist_q, inta_hist_d;
    logic       read_hist_q, read_hist_d;
    logic [7:0] interrupt_when_ack1_q, interrupt_when_ack1_d;
    logic       ack_2_3_q, ack_2_3_d;
    logic [2:0] cascade_out_q, cascade_out_d;
    logic       cascade_io_q, cascade_io_d;
    logic       latch_in_service_q, latch_in_service_d;
    logic       end_of_ack_q, end_of_ack_d;
    logic       end_of_poll_q, end_of_poll_d;

    // Edges are the synchronised value differing from last cycle's value.
    logic inta_fall, inta_rise, read_fall;
    assign inta_fall = inta_hist_q & ~inta_sync;
    assign inta_rise = ~inta_hist_q & inta_sync;
    assign read_fall = read_hist_q & ~read_sync;

    // Only edges that actually move the FSM take part in the priority order;
    // an edge the current state ignores does not block a lower-priority event.
    logic inta_fall_acts, inta_rise_acts, read_fall_acts, poll_acts;
    assign inta_fall_acts = inta_fall &&
                            ((state_q inside {ST_READY, ST_POLL, ST_ACK1}) ||
                             (state_q == ST_ACK2 && !u8086_or_mcs80_config));
    assign inta_rise_acts = inta_rise &&
                            ((state_q == ST_ACK2 && u8086_or_mcs80_config) ||
                             (state_q == ST_ACK3));
    assign read_fall_acts = read_fall && (state_q == ST_POLL);
    assign poll_acts      = poll_command && (state_q == ST_READY);

    // Binary index of the one-hot request (lowest set bit if several).
    logic [2:0] request_index;
    always_comb begin
        request_index = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (highest_level_in_request[i]) request_index = 3'(i);
        end
    end

    // NOTE: every signal gets a default before any branch, so no path through
    // this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d               = state_q;
        inta_hist_d           = inta_sync;
        read_hist_d           = read_sync;
        interrupt_when_ack1_d = interrupt_when_ack1_q;
        ack_2_3_d             = ack_2_3_q;
        cascade_out_d         = cascade_out_q;
        cascade_io_d          = cascade_io_q;
        latch_in_service_d    = 1'b0;
        end_of_ack_d          = 1'b0;
        end_of_poll_d         = 1'b0;

        if (write_initial_command_word_1) begin
            // Abort: back to idle silently, no end-of-sequence pulse.
            state_d       = ST_READY;
            ack_2_3_d     = 1'b0;
            cascade_io_d  = 1'b0;
            cascade_out_d = 3'd0;
        end else if (inta_fall_acts) begin
            case (state_q)
                ST_READY, ST_POLL: begin
                    state_d               = ST_ACK1;
                    interrupt_when_ack1_d = highest_level_in_request;
                    latch_in_service_d    = 1'b1;
                    if (cascade_slave) begin
                        // A cascaded slave learns ownership only from CAS at
                        // the second INTA; a single-mode slave owns the bus.
                        ack_2_3_d     = single_or_cascade_config;
                        cascade_io_d  = 1'b0;
                        cascade_out_d = 3'd0;
                    end else if (single_or_cascade_config ||
                                 ((highest_level_in_request & cascade_device_config) == 8'h00)) begin
                        // No slave behind the winning IR: master answers itself.
                        ack_2_3_d     = 1'b1;
                        cascade_io_d  = 1'b0;
                        cascade_out_d = 3'd0;
                    end else begin
                        // Hand the vector bytes to the slave on that IR.
                        ack_2_3_d     = 1'b0;
                        cascade_io_d  = 1'b1;
                        cascade_out_d = request_index;
                    end
                end
                ST_ACK1: begin
                    state_d = ST_ACK2;
                    if (cascade_slave && !single_or_cascade_config) begin
                        ack_2_3_d = (cascade_in == cascade_device_config[2:0]);
                    end
                end
                ST_ACK2: state_d = ST_ACK3;
                default: state_d = state_q;
            endcase
        end else if (inta_rise_acts) begin
            state_d       = ST_READY;
            end_of_ack_d  = 1'b1;
            ack_2_3_d     = 1'b0;
            cascade_io_d  = 1'b0;
            cascade_out_d = 3'd0;
        end else if (read_fall_acts) begin
            state_d       = ST_READY;
            end_of_poll_d = 1'b1;
            ack_2_3_d     = 1'b0;
            cascade_io_d  = 1'b0;
            cascade_out_d = 3'd0;
        end else if (poll_acts) begin
            state_d = ST_POLL;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q               <= ST_READY;
            inta_hist_q           <= 1'b1;
            read_hist_q           <= 1'b0;
            interrupt_when_ack1_q <= 8'h00;
            ack_2_3_q             <= 1'b0;
            cascade_out_q         <= 3'd0;
            cascade_io_q          <= 1'b0;
            latch_in_service_q    <= 1'b0;
            end_of_ack_q          <= 1'b0;
            end_of_poll_q         <= 1'b0;
        end else begin
            state_q               <= state_d;
            inta_hist_q           <= inta_hist_d;
            read_hist_q           <= read_hist_d;
            interrupt_when_ack1_q <= interrupt_when_ack1_d;
            ack_2_3_q             <= ack_2_3_d;
            cascade_out_q         <= cascade_out_d;
            cascade_io_q          <= cascade_io_d;
            latch_in_service_q    <= latch_in_service_d;
            end_of_ack_q          <= end_of_ack_d;
            end_of_poll_q         <= end_of_poll_d;
        end
    end

    assign control_state               = state_q;
    assign interrupt_when_ack1         = interrupt_when_ack1_q;
    assign cascade_output_ack_2_3      = ack_2_3_q;
    assign cascade_out                 = cascade_out_q;
    assign cascade_io                  = cascade_io_q;
    assign latch_in_service            = latch_in_service_q;
    assign end_of_acknowledge_sequence = end_of_ack_q;
    assign end_of_poll_command         = end_of_poll_q;

endmodule

// File: tb/tb_ack_sequence_controller.sv
// ---------------------------------------------------------------------------
// Testbench for ack_sequence_controller: directed scenarios with literal
// expectations, then randomized transactions, all compared every cycle
// against a behavioural model of the acknowledge sequence.
// ---------------------------------------------------------------------------
module tb_ack_sequence_controller;

    localparam int SYNC = 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       inta_n = 1'b1;
    logic       rd = 1'b0;
    logic       poll_cmd = 1'b0;
    logic       icw1 = 1'b0;
    logic       u8086 = 1'b1;
    logic       single = 1'b1;
    logic       slave = 1'b0;
    logic [7:0] cfg = 8'h00;
    logic [7:0] req = 8'h00;
    logic [2:0] cas_in = 3'd0;

    logic [2:0] control_state;
    logic [7:0] interrupt_when_ack1;
    logic       ack_2_3;
    logic [2:0] cascade_out;
    logic       cascade_io;
    logic       latch_in_service;
    logic       end_of_ack;
    logic       end_of_poll;

    always #5 clock = ~clock;

    ack_sequence_controller #(.SYNC_STAGES(SYNC)) dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .interrupt_acknowledge_n      (inta_n),
        .read                         (rd),
        .poll_command                 (poll_cmd),
        .write_initial_command_word_1 (icw1),
        .u8086_or_mcs80_config        (u8086),
        .single_or_cascade_config     (single),
        .cascade_slave                (slave),
        .cascade_device_config        (cfg),
        .highest_level_in_request     (req),
        .cascade_in                   (cas_in),
        .control_state                (control_state),
        .interrupt_when_ack1          (interrupt_when_ack1),
        .cascade_output_ack_2_3       (ack_2_3),
        .cascade_out                  (cascade_out),
        .cascade_io                   (cascade_io),
        .latch_in_service             (latch_in_service),
        .end_of_acknowledge_sequence  (end_of_ack),
        .end_of_poll_command          (end_of_poll)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model. The sequence is described by how many INTA falling
    // edges have been accepted (0..N, N = 2 for 8086, 3 for MCS-80) plus a
    // polling flag; control_state is simply that count, or 4 while polling.
    // Pins reach the sequencer SYNC clocks late: p[j] holds the pin j edges ago.
    // -----------------------------------------------------------------------
    int         m_pulses;
    bit         m_poll;
    logic [7:0] m_iwa;
    logic       m_ack, m_cio, m_lis, m_eoa, m_eop;
    logic [2:0] m_cout;
    logic       pi [1:SYNC+1];
    logic       pr [1:SYNC+1];
    int         m_n;
    logic       i_fall, i_rise, r_fall;

    task automatic go_ready();
        m_pulses = 0;
        m_poll   = 1'b0;
        m_ack    = 1'b0;
        m_cio    = 1'b0;
        m_cout   = 3'd0;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            go_ready();
            m_iwa = 8'h00;
            m_lis = 1'b0;
            m_eoa = 1'b0;
            m_eop = 1'b0;
            for (int k = 1; k <= SYNC + 1; k++) begin
                pi[k] = 1'b1;
                pr[k] = 1'b0;
            end
        end else begin
            m_n    = u8086 ? 2 : 3;
            i_fall = pi[SYNC+1] && !pi[SYNC];
            i_rise = !pi[SYNC+1] && pi[SYNC];
            r_fall = pr[SYNC+1] && !pr[SYNC];
            m_lis  = 1'b0;
            m_eoa  = 1'b0;
            m_eop  = 1'b0;
            if (icw1) begin
                go_ready();
            end else if (i_fall && m_pulses < m_n) begin
                m_poll = 1'b0;
                m_pulses++;
                if (m_pulses == 1) begin
                    m_iwa = req;
                    m_lis = 1'b1;
                    m_cio = 1'b0;
                    m_cout = 3'd0;
                    if (slave) begin
                        m_ack = single;
                    end else if (!single && (req & cfg) != 8'h00) begin
                        m_ack = 1'b0;
                        m_cio = 1'b1;
                        for (int b = 0; b < 8; b++) if (req[b]) m_cout = 3'(b);
                    end else begin
                        m_ack = 1'b1;
                    end
                end else if (m_pulses == 2 && slave && !single) begin
                    m_ack = (cas_in == cfg[2:0]);
                end
            end else if (i_rise && m_pulses == m_n) begin
                go_ready();
                m_eoa = 1'b1;
            end else if (r_fall && m_poll) begin
                go_ready();
                m_eop = 1'b1;
            end else if (poll_cmd && !m_poll && m_pulses == 0) begin
                m_poll = 1'b1;
            end
            for (int k = SYNC + 1; k > 1; k--) begin
                pi[k] = pi[k-1];
                pr[k] = pr[k-1];
            end
            pi[1] = inta_n;
            pr[1] = rd;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cmp_state", control_state, m_poll ? 32'd4 : m_pulses);
            check("cmp_iwa", interrupt_when_ack1, m_iwa);
            check("cmp_ack_2_3", ack_2_3, m_ack);
            check("cmp_cas_out", cascade_out, m_cout);
            check("cmp_cas_io", cascade_io, m_cio);
            check("cmp_latch_is", latch_in_service, m_lis);
            check("cmp_end_ack", end_of_ack, m_eoa);
            check("cmp_end_poll", end_of_poll, m_eop);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic pulse(input int exp_low, input int exp_end);
        inta_n = 1'b0;
        step(4);
        check("pulse_low_state", control_state, exp_low);
        inta_n = 1'b1;
        step(4);
        check("pulse_end_state", control_state, exp_end);
    endtask

    bit noise_icw = 1'b0;

    task automatic cyc();
        int r;
        r = $urandom_range(0, 8);
        req = (r == 8) ? 8'h00 : (8'h01 << r);
        cas_in = ($urandom_range(0, 1) == 1) ? cfg[2:0] : 3'($urandom_range(0, 7));
        poll_cmd = ($urandom_range(0, 15) == 0);
        icw1 = noise_icw && ($urandom_range(0, 19) == 0);
        step(1);
        poll_cmd = 1'b0;
        icw1 = 1'b0;
    endtask

    task automatic rand_pulse();
        inta_n = 1'b0;
        repeat ($urandom_range(1, 4)) cyc();
        inta_n = 1'b1;
        repeat ($urandom_range(1, 4)) cyc();
    endtask

    initial begin
        int kind, np;

        reset_n = 1'b0;
        step(3);
        check("reset_state", control_state, 0);
        check("reset_ack", ack_2_3, 0);
        check("reset_iwa", interrupt_when_ack1, 0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        step(2);

        // 8086, single-mode master, request 8'h20
        u8086 = 1'b1; single = 1'b1; slave = 1'b0; req = 8'h20;
        inta_n = 1'b0;
        step(2);
        check("latency_not_yet", control_state, 0);
        step(1);
        check("t1_ack1", control_state, 1);
        check("t1_lis", latch_in_service, 1);
        check("t1_iwa", interrupt_when_ack1, 8'h20);
        check("t1_ack_2_3", ack_2_3, 1);
        step(1);
        check("t1_lis_one_cycle", latch_in_service, 0);
        inta_n = 1'b1;
        step(4);
        check("t1_rise_ignored", control_state, 1);
        inta_n = 1'b0;
        step(4);
        check("t1_ack2", control_state, 2);
        inta_n = 1'b1;
        step(3);
        check("t1_ready", control_state, 0);
        check("t1_eoa", end_of_ack, 1);
        check("t1_ack_clear", ack_2_3, 0);
        step(1);
        check("t1_eoa_one_cycle", end_of_ack, 0);
        check("t1_iwa_kept", interrupt_when_ack1, 8'h20);

        // MCS-80: three pulses, a fourth starts a new sequence
        u8086 = 1'b0;
        pulse(1, 1);
        pulse(2, 2);
        pulse(3, 0);
        pulse(1, 1);
        icw1 = 1'b1; step(1); icw1 = 1'b0;
        check("t2_icw1_ready", control_state, 0);
        step(2);

        // Cascade master, slave on IR2
        u8086 = 1'b1; single = 1'b0; cfg = 8'h04; req = 8'h04;
        pulse(1, 1);
        check("t3_cas_io", cascade_io, 1);
        check("t3_cas_out", cascade_out, 2);
        check("t3_ack_2_3", ack_2_3, 0);
        pulse(2, 0);
        check("t3_cas_io_clr", cascade_io, 0);
        check("t3_cas_out_clr", cascade_out, 0);

        // Slave with ID 5
        slave = 1'b1; cfg = 8'h05; cas_in = 3'd5;
        pulse(1, 1);
        check("t4_ack_before", ack_2_3, 0);
        inta_n = 1'b0; step(4);
        check("t4_match_ack", ack_2_3, 1);
        inta_n = 1'b1; step(4);
        check("t4_ready", control_state, 0);
        cas_in = 3'd4;
        pulse(1, 1);
        inta_n = 1'b0; step(4);
        check("t4_nomatch_ack", ack_2_3, 0);
        inta_n = 1'b1; step(4);

        // Poll
        slave = 1'b0; single = 1'b1;
        poll_cmd = 1'b1; step(1); poll_cmd = 1'b0;
        check("t5_poll", control_state, 4);
        rd = 1'b1; step(4);
        check("t5_read_high", control_state, 4);
        rd = 1'b0; step(3);
        check("t5_ready", control_state, 0);
        check("t5_eop", end_of_poll, 1);
        step(1);
        check("t5_eop_one_cycle", end_of_poll, 0);
        poll_cmd = 1'b1; step(1); poll_cmd = 1'b0;
        pulse(1, 1);
        pulse(2, 0);

        // ICW1 in ACK2, then async reset in ACK2
        u8086 = 1'b0; req = 8'h80;
        pulse(1, 1);
        inta_n = 1'b0; step(4);
        check("t6_ack2", control_state, 2);
        icw1 = 1'b1; step(1); icw1 = 1'b0;
        check("t6_icw1_ready", control_state, 0);
        check("t6_no_eoa", end_of_ack, 0);
        inta_n = 1'b1; step(4);
        check("t6_rise_ignored", control_state, 0);
        pulse(1, 1);
        inta_n = 1'b0; step(4);
        check("t6_ack2_again", control_state, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_state", control_state, 0);
        check("t6_rst_iwa", interrupt_when_ack1, 0);
        check("t6_rst_ack", ack_2_3, 0);
        inta_n = 1'b1;
        step(2);
        reset_n = 1'b1;
        step(2);

        // Randomized transactions
        for (int t = 0; t < 250; t++) begin
            inta_n = 1'b1; rd = 1'b0; poll_cmd = 1'b0; icw1 = 1'b0; noise_icw = 1'b0;
            step(5);
            if (m_poll || m_pulses != 0) begin
                icw1 = 1'b1; step(1); icw1 = 1'b0; step(1);
            end
            u8086  = 1'($urandom_range(0, 1));
            single = 1'($urandom_range(0, 1));
            slave  = 1'($urandom_range(0, 1));
            cfg    = 8'($urandom);
            kind   = $urandom_range(0, 3);
            noise_icw = (kind == 3);
            if (kind == 2) begin
                poll_cmd = 1'b1; step(1); poll_cmd = 1'b0;
                repeat ($urandom_range(0, 3)) cyc();
                if ($urandom_range(0, 3) == 0) begin
                    rand_pulse();
                end else begin
                    rd = 1'b1;
                    repeat ($urandom_range(1, 3)) cyc();
                    rd = 1'b0;
                    repeat ($urandom_range(3, 5)) cyc();
                end
            end else begin
                np = (u8086 ? 2 : 3) + $urandom_range(0, 2) - 1;
                repeat (np) rand_pulse();
            end
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
